// File: rtl/pc_sequencer.sv
// Fetch-PC unit: owns the PC, resolves branches/jumps, and parks redirects during fetch stalls.
// Optional exception entry/return support is compiled in with `define PC_EXC_EN.
module pc_sequencer #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000
`ifdef PC_EXC_EN
    ,
    parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h0000_4180
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             fetch_ready,
    input  logic             dec_valid,
    input  logic [WIDTH-1:0] dec_pc,
    input  logic [2:0]       br_op,
    input  logic [1:0]       jump_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    input  logic [25:0]      index26,
`ifdef PC_EXC_EN
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] epc_o,
`endif
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] link_o,
    output logic             taken_o,
    output logic             align_err_o
);

    localparam logic [WIDTH-1:0] Four = WIDTH'(4);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             pend_v_q, pend_v_d;
    logic             align_q, align_d;
`ifdef PC_EXC_EN
    logic [WIDTH-1:0] epc_q, epc_d;
`endif

    logic [WIDTH-1:0] seq_pc, br_tgt, j_tgt, jr_tgt, rq_tgt;
    logic             rs_neg, rs_zero, br_true, jr_sel, jr_mis, rq, adv;

    assign seq_pc  = dec_pc + Four;
    assign rs_neg  = rs_val[WIDTH-1];
    assign rs_zero = (rs_val == '0);
    assign br_tgt  = seq_pc + {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign j_tgt   = {seq_pc[WIDTH-1:28], index26, 2'b00};
    assign jr_tgt  = {rs_val[WIDTH-1:2], 2'b00};
    assign adv     = ~stall & fetch_ready;

    always_comb begin
        br_true = 1'b0;
        case (br_op)
            3'd1:    br_true = (rs_val == rt_val);
            3'd2:    br_true = (rs_val != rt_val);
            3'd3:    br_true = rs_neg | rs_zero;
            3'd4:    br_true = ~rs_neg & ~rs_zero;
            3'd5:    br_true = rs_neg;
            3'd6:    br_true = ~rs_neg;
            default: br_true = 1'b0;
        endcase
    end

    // A true branch beats a simultaneous jump; otherwise the jump decides the target.
    assign jr_sel = ~br_true & (jump_op == 2'd3);
    assign jr_mis = jr_sel & (rs_val[1:0] != 2'b00);
    assign rq     = dec_valid & (br_true | (jump_op != 2'd0));
    assign rq_tgt = br_true ? br_tgt : (jr_sel ? jr_tgt : j_tgt);

    always_comb begin
        pc_d     = pc_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        align_d  = 1'b0;
`ifdef PC_EXC_EN
        epc_d    = epc_q;
        if (exc_req) begin
            pc_d     = EXC_VECTOR;
            epc_d    = dec_valid ? dec_pc : pc_q;
            pend_v_d = 1'b0;
        end else if (adv && eret) begin
            pc_d     = epc_q;
            pend_v_d = 1'b0;
        end else
`endif
        if (adv) begin
            // Any advance retires the pending slot; a fresh redirect supersedes it.
            pend_v_d = 1'b0;
            if (rq) begin
                pc_d    = rq_tgt;
                align_d = jr_mis;
            end else if (pend_v_q) begin
                pc_d = pend_q;
            end else begin
                pc_d = pc_q + Four;
            end
        end else if (rq) begin
            pend_d   = rq_tgt;
            pend_v_d = 1'b1;
            align_d  = jr_mis;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            align_q  <= 1'b0;
`ifdef PC_EXC_EN
            epc_q    <= '0;
`endif
        end else begin
            pc_q     <= {pc_d[WIDTH-1:2], 2'b00};
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            align_q  <= align_d;
`ifdef PC_EXC_EN
            epc_q    <= epc_d;
`endif
        end
    end

    assign pc_o        = pc_q;
    assign link_o      = seq_pc;
    assign taken_o     = rq;
    assign align_err_o = align_q;
`ifdef PC_EXC_EN
    assign epc_o       = epc_q;
`endif

endmodule
